// File: rtl/ddr2_host_arbiter_if.sv
// rtl/ddr2_host_arbiter_if.sv - requester, write-data, read-return and DDR2 host-port signals
interface ddr2_host_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [3*NREQ-1:0]  req_cmd;
    logic [2*NREQ-1:0]  req_sz;
    logic [3*NREQ-1:0]  req_op;
    logic [25*NREQ-1:0] req_addr;
    logic [NREQ-1:0]    wr_valid;
    logic [16*NREQ-1:0] wr_data;
    logic [NREQ-1:0]    wr_ready;
    logic [NREQ-1:0]    rd_valid;
    logic [15:0]        rd_data;
    logic [24:0]        rd_addr;
    logic [2:0]         cmd;
    logic [1:0]         sz;
    logic [2:0]         op;
    logic [24:0]        addr;
    logic [15:0]        din;
    logic               fetching;
    logic               notfull;
    logic [6:0]         fillcount;
    logic [15:0]        dout;
    logic [24:0]        raddr;
    logic               validout;
    logic               busy;
    logic               err;

    modport slave (
        input  req_valid, req_cmd, req_sz, req_op, req_addr, wr_valid, wr_data,
               notfull, fillcount, dout, raddr, validout,
        output req_ready, wr_ready, rd_valid, rd_data, rd_addr,
               cmd, sz, op, addr, din, fetching, busy, err
    );

    modport master (
        output req_valid, req_cmd, req_sz, req_op, req_addr, wr_valid, wr_data,
               notfull, fillcount, dout, raddr, validout,
        input  req_ready, wr_ready, rd_valid, rd_data, rd_addr,
               cmd, sz, op, addr, din, fetching, busy, err
    );
endinterface

// File: rtl/ddr2_host_arbiter.sv
// rtl/ddr2_host_arbiter.sv - round-robin sharing of one DDR2 controller host port between NREQ requesters
module ddr2_host_arbiter #(
    parameter int NREQ       = 2,
    parameter int TAG_DEPTH  = 8,
    parameter int FILL_LIMIT = 32
) (
    input  logic               clk,
    input  logic               reset,
    ddr2_host_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW = $clog2(TAG_DEPTH);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_SCR = 3'd1;
    localparam logic [2:0] CMD_SCW = 3'd2;
    localparam logic [2:0] CMD_BLR = 3'd3;
    localparam logic [2:0] CMD_BLW = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WDATA} state_t;

    function automatic logic is_read(input logic [2:0] c);
        return (c == CMD_SCR) || (c == CMD_BLR);
    endfunction

    function automatic logic [5:0] word_count(input logic [2:0] c, input logic [1:0] s);
        if (c == CMD_BLR || c == CMD_BLW)
            return {({1'b0, s} + 3'd1), 3'b000};
        return 6'd1;
    endfunction

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   cur;
    logic [2:0]      lat_cmd;
    logic [1:0]      lat_sz;
    logic [2:0]      lat_op;
    logic [24:0]     lat_addr;
    logic [5:0]      lat_cnt;
    logic [5:0]      rem;

    logic [2:0]      cmd_r;
    logic [1:0]      sz_r;
    logic [2:0]      op_r;
    logic [24:0]     addr_r;
    logic [15:0]     din_r;
    logic            fetching_r;
    logic            err_r;

    logic [IW-1:0]   tag_id  [TAG_DEPTH];
    logic [5:0]      tag_cnt [TAG_DEPTH];
    logic [AW-1:0]   wp, rp;
    logic [AW:0]     fill;
    logic            tag_full, tag_empty, tag_push, tag_pop, ret_hit;

    logic [NREQ-1:0] elig;
    logic [2:0]      c_i;
    logic            gnt_found;
    logic [IW-1:0]   gnt;
    logic [IW-1:0]   idx;
    logic [2:0]      g_cmd;
    logic [1:0]      g_sz;
    logic [2:0]      g_op;
    logic [24:0]     g_addr;
    logic            cur_wv;
    logic [15:0]     cur_wd;
    logic            wr_go;
    logic [NREQ-1:0] req_ready_c, wr_ready_c, rd_valid_c;

    // Eligibility uses the registered fill level, so a pop in the same cycle does not free a slot yet
    assign tag_full  = (fill == (AW+1)'(TAG_DEPTH));
    assign tag_empty = (fill == '0);
    assign ret_hit   = bus.validout && !tag_empty;
    assign tag_pop   = ret_hit && (tag_cnt[rp] == 6'd1);
    assign tag_push  = (state == S_ISSUE) && bus.notfull && is_read(lat_cmd);

    always_comb begin
        elig = '0;
        c_i  = '0;
        for (int i = 0; i < NREQ; i++) begin
            c_i     = bus.req_cmd[3*i +: 3];
            elig[i] = bus.req_valid[i] && bus.notfull
                      && !(is_read(c_i) && tag_full)
                      && !((c_i == CMD_BLW) && (bus.fillcount > 7'(FILL_LIMIT)));
        end
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt       = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (!gnt_found && elig[idx]) begin
                gnt_found = 1'b1;
                gnt       = idx;
            end
        end
    end

    always_comb begin
        g_cmd  = '0;
        g_sz   = '0;
        g_op   = '0;
        g_addr = '0;
        cur_wv = 1'b0;
        cur_wd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == IW'(i)) begin
                g_cmd  = bus.req_cmd[3*i +: 3];
                g_sz   = bus.req_sz[2*i +: 2];
                g_op   = bus.req_op[3*i +: 3];
                g_addr = bus.req_addr[25*i +: 25];
            end
            if (cur == IW'(i)) begin
                cur_wv = bus.wr_valid[i];
                cur_wd = bus.wr_data[16*i +: 16];
            end
        end
    end

    assign wr_go = bus.notfull && cur_wv &&
                   (((state == S_ISSUE) && !is_read(lat_cmd)) || (state == S_WDATA));

    always_comb begin
        req_ready_c = '0;
        wr_ready_c  = '0;
        rd_valid_c  = '0;
        if ((state == S_IDLE) && gnt_found)
            req_ready_c[gnt] = 1'b1;
        if (wr_go)
            wr_ready_c[cur] = 1'b1;
        if (ret_hit)
            rd_valid_c[tag_id[rp]] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            cur        <= '0;
            lat_cmd    <= CMD_NOP;
            lat_sz     <= '0;
            lat_op     <= '0;
            lat_addr   <= '0;
            lat_cnt    <= '0;
            rem        <= '0;
            cmd_r      <= CMD_NOP;
            sz_r       <= '0;
            op_r       <= '0;
            addr_r     <= '0;
            din_r      <= '0;
            fetching_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            cmd_r      <= CMD_NOP;
            fetching_r <= 1'b0;
            err_r      <= bus.validout && tag_empty;
            case (state)
                S_IDLE: begin
                    if (gnt_found) begin
                        rr_ptr   <= (gnt == IW'(NREQ-1)) ? '0 : gnt + 1'b1;
                        cur      <= gnt;
                        lat_cmd  <= g_cmd;
                        lat_sz   <= g_sz;
                        lat_op   <= g_op;
                        lat_addr <= g_addr;
                        lat_cnt  <= word_count(g_cmd, g_sz);
                        // Invalid commands are consumed and flagged; NOP is consumed silently
                        if (g_cmd > CMD_BLW)
                            err_r <= 1'b1;
                        else if (g_cmd != CMD_NOP)
                            state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.notfull && (is_read(lat_cmd) || cur_wv)) begin
                        cmd_r      <= lat_cmd;
                        sz_r       <= lat_sz;
                        op_r       <= lat_op;
                        addr_r     <= lat_addr;
                        fetching_r <= 1'b1;
                        if (is_read(lat_cmd)) begin
                            state <= S_IDLE;
                        end else begin
                            din_r <= cur_wd;
                            rem   <= lat_cnt - 6'd1;
                            state <= (lat_cnt == 6'd1) ? S_IDLE : S_WDATA;
                        end
                    end
                end
                S_WDATA: begin
                    if (wr_go) begin
                        din_r      <= cur_wd;
                        fetching_r <= 1'b1;
                        rem        <= rem - 6'd1;
                        if (rem == 6'd1)
                            state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp   <= '0;
            rp   <= '0;
            fill <= '0;
        end else begin
            if (tag_push)
                wp <= wp + 1'b1;
            if (tag_pop)
                rp <= rp + 1'b1;
            case ({tag_push, tag_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // Head entry counts down in place; push never targets the head slot while it is live
    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_id[wp]  <= cur;
            tag_cnt[wp] <= lat_cnt;
        end
        if (ret_hit && !tag_pop)
            tag_cnt[rp] <= tag_cnt[rp] - 6'd1;
    end

    assign bus.req_ready = req_ready_c;
    assign bus.wr_ready  = wr_ready_c;
    assign bus.rd_valid  = rd_valid_c;
    assign bus.rd_data   = bus.dout;
    assign bus.rd_addr   = bus.raddr;
    assign bus.cmd       = cmd_r;
    assign bus.sz        = sz_r;
    assign bus.op        = op_r;
    assign bus.addr      = addr_r;
    assign bus.din       = din_r;
    assign bus.fetching  = fetching_r;
    assign bus.err       = err_r;
    assign bus.busy      = (state != S_IDLE) || !tag_empty;
endmodule

// File: tb/tb_ddr2_host_arbiter.sv
// tb/tb_ddr2_host_arbiter.sv - directed self-checking bench for ddr2_host_arbiter
module tb_ddr2_host_arbiter;
    localparam int NREQ = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_fetch = 0;
    int   n_wr0 = 0;
    int   n_wr1 = 0;
    logic [15:0] din_log [$];
    logic [2:0]  cmd_log [$];
    int          grant_log [$];

    ddr2_host_arbiter_if #(.NREQ(NREQ)) ifc ();

    ddr2_host_arbiter #(.NREQ(NREQ), .TAG_DEPTH(8), .FILL_LIMIT(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #2;
        if (ifc.fetching === 1'b1) begin
            n_fetch++;
            din_log.push_back(ifc.din);
            cmd_log.push_back(ifc.cmd);
        end
        if (ifc.wr_ready[0] === 1'b1) n_wr0++;
        if (ifc.wr_ready[1] === 1'b1) n_wr1++;
        for (int i = 0; i < NREQ; i++)
            if (ifc.req_ready[i] === 1'b1) grant_log.push_back(i);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        ifc.req_valid = '0;
        ifc.req_cmd   = '0;
        ifc.req_sz    = '0;
        ifc.req_op    = '0;
        ifc.req_addr  = '0;
        ifc.wr_valid  = '0;
        ifc.wr_data   = '0;
        ifc.notfull   = 1'b1;
        ifc.fillcount = '0;
        ifc.dout      = '0;
        ifc.raddr     = '0;
        ifc.validout  = 1'b0;
    endtask

    task automatic set_req(input int id, input logic [2:0] c, input logic [1:0] s, input logic [24:0] a);
        ifc.req_cmd[3*id +: 3]   = c;
        ifc.req_sz[2*id +: 2]    = s;
        ifc.req_op[3*id +: 3]    = 3'd5;
        ifc.req_addr[25*id +: 25] = a;
        ifc.req_valid[id]        = 1'b1;
    endtask

    task automatic run_write(input int id, input logic [2:0] c, input logic [1:0] s, input logic [24:0] a,
                             input logic [15:0] base, input int nwords, input int drop_at, input int stop_at);
        int k, drop_left, f0, w0, d0;
        bit dropped, granted;
        k = 0; drop_left = 0; dropped = 0; granted = 0;
        f0 = n_fetch; w0 = (id == 0) ? n_wr0 : n_wr1; d0 = din_log.size();
        for (int cyc = 0; cyc < 80 && k < nwords && k != stop_at; cyc++) begin
            @(negedge clk);
            if (cyc == 0) set_req(id, c, s, a);
            if (granted) ifc.req_valid[id] = 1'b0;
            if (k == drop_at && !dropped) begin dropped = 1; drop_left = 3; end
            ifc.notfull = (drop_left == 0);
            if (drop_left > 0) drop_left--;
            ifc.wr_valid[id] = 1'b1;
            ifc.wr_data[16*id +: 16] = base + 16'(k);
            #1;
            if (ifc.req_ready[id]) granted = 1;
            if (ifc.wr_ready[id]) k++;
        end
        ifc.notfull = 1'b1;
        ifc.req_valid[id] = 1'b0;
        check_eq("wr_grant", 32'(granted), 32'd1);
        if (stop_at < 0) begin
            @(negedge clk);
            ifc.wr_valid[id] = 1'b0;
            @(negedge clk);
            @(negedge clk);
            #3;
            check_eq("wr_ready_cnt", 32'(((id == 0) ? n_wr0 : n_wr1) - w0), 32'(nwords));
            check_eq("fetch_cnt", 32'(n_fetch - f0), 32'(nwords));
            for (int j = 0; j < nwords; j++) begin
                check_eq("din_seq", 32'(din_log[d0+j]), 32'(base + 16'(j)));
                check_eq("cmd_seq", 32'(cmd_log[d0+j]), (j == 0) ? 32'(c) : 32'd0);
            end
            check_eq("wr_addr", 32'(ifc.addr), 32'(a));
        end
    endtask

    initial begin
        int ng, g0, f0;
        reset = 1'b0;
        idle_inputs();
        @(negedge clk); #1;
        check_eq("rst_cmd", 32'(ifc.cmd), 32'd0);
        check_eq("rst_fetching", 32'(ifc.fetching), 32'd0);
        check_eq("rst_busy", 32'(ifc.busy), 32'd0);
        check_eq("rst_err", 32'(ifc.err), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // single-word write from requester 0
        run_write(0, 3'd2, 2'd0, 25'h10, 16'hA5A5, 1, -1, -1);

        // BLW above the fill limit is held off, then granted at the limit
        @(negedge clk);
        set_req(0, 3'd4, 2'd0, 25'h300);
        ifc.fillcount = 7'd33;
        #1;
        check_eq("fill_block", 32'(ifc.req_ready), 32'd0);
        ifc.req_valid = '0;
        ifc.fillcount = 7'd32;
        run_write(0, 3'd4, 2'd0, 25'h300, 16'h3000, 8, -1, -1);
        ifc.fillcount = 7'd0;

        // 16-word BLW from requester 1 with a 3-cycle notfull gap at word 6
        run_write(1, 3'd4, 2'd1, 25'h200, 16'h1000, 16, 6, -1);

        // both requesters stream BLR: grants alternate, returns follow issue order
        g0 = grant_log.size();
        ng = 0;
        for (int cyc = 0; cyc < 20 && ng < 4; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                set_req(0, 3'd3, 2'd0, 25'h100);
                set_req(1, 3'd3, 2'd0, 25'h180);
            end
            #1;
            if (ifc.req_ready != '0) ng++;
        end
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            ifc.req_valid = '0;
            ifc.validout  = 1'b1;
            ifc.dout      = 16'hD000 + 16'(k);
            ifc.raddr     = 25'(k);
            #1;
            check_eq("rd_route", 32'(ifc.rd_valid), ((k / 8) % 2 == 0) ? 32'd1 : 32'd2);
            check_eq("rd_data", 32'(ifc.rd_data), 32'hD000 + 32'(k));
        end
        @(negedge clk);
        ifc.validout = 1'b0;
        #1;
        for (int j = 0; j < 4; j++)
            check_eq("grant_order", 32'(grant_log[g0+j]), 32'(j % 2));
        check_eq("blr_busy_done", 32'(ifc.busy), 32'd0);
        check_eq("blr_no_err", 32'(ifc.err), 32'd0);

        // eight outstanding SCRs fill the tag FIFO; one return lets the ninth through
        ng = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (cyc == 0) set_req(0, 3'd1, 2'd0, 25'h40);
            #1;
            if (ifc.req_ready[0]) ng++;
        end
        check_eq("scr_grants", 32'(ng), 32'd8);
        check_eq("scr_busy", 32'(ifc.busy), 32'd1);
        @(negedge clk);
        ifc.validout = 1'b1;
        #1;
        check_eq("scr_pop_route", 32'(ifc.rd_valid), 32'd1);
        check_eq("scr_full_same_cycle", 32'(ifc.req_ready), 32'd0);
        @(negedge clk);
        ifc.validout = 1'b0;
        #1;
        check_eq("scr_ninth_grant", 32'(ifc.req_ready), 32'd1);
        @(negedge clk);
        ifc.req_valid = '0;
        @(negedge clk); #1;
        check_eq("scr_ninth_cmd", 32'(ifc.cmd), 32'd1);
        check_eq("scr_ninth_fetch", 32'(ifc.fetching), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ifc.validout = 1'b1;
        end
        @(negedge clk);
        ifc.validout = 1'b0;
        #1;
        check_eq("scr_drained", 32'(ifc.busy), 32'd0);

        // stray return word with nothing outstanding
        @(negedge clk);
        ifc.validout = 1'b1;
        #1;
        check_eq("stray_rd_valid", 32'(ifc.rd_valid), 32'd0);
        @(negedge clk);
        ifc.validout = 1'b0;
        #1;
        check_eq("stray_err", 32'(ifc.err), 32'd1);
        @(negedge clk); #1;
        check_eq("stray_err_pulse", 32'(ifc.err), 32'd0);

        // invalid command is accepted, flagged, never issued
        @(negedge clk);
        set_req(0, 3'd6, 2'd0, 25'h55);
        #1;
        check_eq("inv_ready", 32'(ifc.req_ready), 32'd1);
        @(negedge clk);
        ifc.req_valid = '0;
        #1;
        check_eq("inv_err", 32'(ifc.err), 32'd1);
        check_eq("inv_cmd", 32'(ifc.cmd), 32'd0);
        check_eq("inv_busy", 32'(ifc.busy), 32'd0);
        @(negedge clk); #1;
        check_eq("inv_no_fetch", 32'(ifc.fetching), 32'd0);

        // reset in the middle of an 8-word BLW
        run_write(0, 3'd4, 2'd0, 25'h700, 16'h5000, 8, -1, 5);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_cmd", 32'(ifc.cmd), 32'd0);
        check_eq("mid_rst_fetch", 32'(ifc.fetching), 32'd0);
        check_eq("mid_rst_din", 32'(ifc.din), 32'd0);
        check_eq("mid_rst_addr", 32'(ifc.addr), 32'd0);
        check_eq("mid_rst_busy", 32'(ifc.busy), 32'd0);
        check_eq("mid_rst_wr_ready", 32'(ifc.wr_ready), 32'd0);
        f0 = n_fetch;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        check_eq("post_rst_no_fetch", 32'(n_fetch - f0), 32'd0);
        @(negedge clk);
        ifc.wr_valid = '0;
        set_req(0, 3'd7, 2'd0, 25'h0);
        set_req(1, 3'd7, 2'd0, 25'h0);
        #1;
        check_eq("post_rst_rr_ptr", 32'(ifc.req_ready), 32'd1);
        @(negedge clk);
        ifc.req_valid = '0;
        #1;
        check_eq("post_rst_inv_err", 32'(ifc.err), 32'd1);
        check_eq("post_rst_cmd", 32'(ifc.cmd), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
